// File: rtl/id_ext_stage_ctrl.sv
// id_ext_stage_ctrl
//   ID-stage control around the immediate extender of a 5-stage MIPS pipeline.
//   Holds the IF/ID register, decodes the opcode into an extender select,
//   registers the extended immediate into ID/EX, and resolves load-use hazards
//   by stalling IF/ID and injecting a bubble into ID/EX.
//
// Build option: define STALL_STATS_EN to add the stall_count output.
//
// Ports:
//   clk          pipeline clock, rising edge
//   reset        asynchronous active-high reset
//   if_instr     instruction fetched in IF
//   if_pc        PC of if_instr
//   flush        redirect: IF/ID becomes NOP_INSTR at the next edge
//   ex_mem_read  instruction in EX is a load
//   ex_rt        destination register of the EX load
//   stall        load-use stall (PC and IF/ID hold)
//   id_instr     IF/ID instruction register
//   id_pc        IF/ID PC register
//   id_ext_sel   decoded select: 0 zero, 1 sign, 2 upper, 3 none
//   ex_instr     ID/EX instruction register
//   ex_pc        ID/EX PC register
//   ex_imm_ext   ID/EX extended immediate
//   ex_ext_sel   ID/EX copy of id_ext_sel
//   ex_valid     0 when ID/EX holds a bubble
//   stall_count  (STALL_STATS_EN only) number of stall cycles, wraps
module id_ext_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  output logic        stall,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [1:0]  id_ext_sel,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm_ext,
  output logic [1:0]  ex_ext_sel,
  output logic        ex_valid
`ifdef STALL_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam logic [1:0] SEL_ZERO  = 2'd0;
  localparam logic [1:0] SEL_SIGN  = 2'd1;
  localparam logic [1:0] SEL_UPPER = 2'd2;
  localparam logic [1:0] SEL_NONE  = 2'd3;

  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] ex_instr_q, ex_instr_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [31:0] ex_imm_q, ex_imm_d;
  logic [1:0]  ex_sel_q, ex_sel_d;
  logic        ex_valid_q, ex_valid_d;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic [1:0]  ext_sel;
  logic [31:0] imm_ext;
  logic        uses_rs, uses_rt;
  logic        stall_w;

  assign opcode = id_instr_q[31:26];
  assign rs     = id_instr_q[25:21];
  assign rt     = id_instr_q[20:16];
  assign imm    = id_instr_q[15:0];

  // Opcode decode: extender select and source-register usage.
  always_comb begin
    ext_sel = SEL_NONE;
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    unique case (opcode)
      6'b001101, 6'b001100: ext_sel = SEL_ZERO;
      6'b001001, 6'b001000, 6'b001010, 6'b100011: ext_sel = SEL_SIGN;
      6'b101011, 6'b000100: begin
        ext_sel = SEL_SIGN;
        uses_rt = 1'b1;
      end
      6'b001111: begin
        ext_sel = SEL_UPPER;
        uses_rs = 1'b0;
      end
      6'b000010, 6'b000011: uses_rs = 1'b0;
      6'b000000: uses_rt = 1'b1;
      default: ext_sel = SEL_NONE;
    endcase
  end

  always_comb begin
    imm_ext = '0;
    unique case (ext_sel)
      SEL_ZERO:  imm_ext = {16'h0000, imm};
      SEL_SIGN:  imm_ext = {{16{imm[15]}}, imm};
      SEL_UPPER: imm_ext = {imm, 16'h0000};
      default:   imm_ext = '0;
    endcase
  end

  // $0 is never a real dependency, so ex_rt == 0 cannot stall.
  assign stall_w = ex_mem_read && (ex_rt != 5'd0) &&
                   ((uses_rs && (ex_rt == rs)) || (uses_rt && (ex_rt == rt)));

  // Flush outranks stall for IF/ID; ID/EX ignores flush so the branch resolving
  // in ID still advances, but still takes the bubble when flush and stall coincide.
  always_comb begin
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    if (flush) begin
      id_instr_d = NOP_INSTR;
      id_pc_d    = if_pc;
    end else if (!stall_w) begin
      id_instr_d = if_instr;
      id_pc_d    = if_pc;
    end
  end

  always_comb begin
    ex_instr_d = NOP_INSTR;
    ex_pc_d    = ex_pc_q;
    ex_imm_d   = '0;
    ex_sel_d   = SEL_NONE;
    ex_valid_d = 1'b0;
    if (!stall_w) begin
      ex_instr_d = id_instr_q;
      ex_pc_d    = id_pc_q;
      ex_imm_d   = imm_ext;
      ex_sel_d   = ext_sel;
      ex_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= RESET_PC;
      ex_instr_q <= NOP_INSTR;
      ex_pc_q    <= RESET_PC;
      ex_imm_q   <= '0;
      ex_sel_q   <= SEL_NONE;
      ex_valid_q <= 1'b0;
    end else begin
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      ex_instr_q <= ex_instr_d;
      ex_pc_q    <= ex_pc_d;
      ex_imm_q   <= ex_imm_d;
      ex_sel_q   <= ex_sel_d;
      ex_valid_q <= ex_valid_d;
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = stall_w ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif

  assign stall      = stall_w;
  assign id_instr   = id_instr_q;
  assign id_pc      = id_pc_q;
  assign id_ext_sel = ext_sel;
  assign ex_instr   = ex_instr_q;
  assign ex_pc      = ex_pc_q;
  assign ex_imm_ext = ex_imm_q;
  assign ex_ext_sel = ex_sel_q;
  assign ex_valid   = ex_valid_q;

endmodule

// File: tb/tb_id_ext_stage_ctrl.sv
module tb_id_ext_stage_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] ORI    = 32'h3401_8001;
  localparam logic [31:0] ADDIU  = 32'h2402_8001;
  localparam logic [31:0] LUI3   = 32'h3C03_1234;
  localparam logic [31:0] ADDU   = 32'h00A7_3021; // addu $6,$5,$7
  localparam logic [31:0] LUI5   = 32'h3C05_0001; // lui $5,1
  localparam logic [31:0] BEQ    = 32'h1022_0004; // beq $1,$2,4

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_instr, if_pc;
  logic        flush, ex_mem_read;
  logic [4:0]  ex_rt;
  logic        stall;
  logic [31:0] id_instr, id_pc, ex_instr, ex_pc, ex_imm_ext;
  logic [1:0]  id_ext_sel, ex_ext_sel;
  logic        ex_valid;
`ifdef STALL_STATS_EN
  logic [31:0] stall_count;
`endif

  id_ext_stage_ctrl #(.RESET_PC(RST_PC), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .stall(stall),
    .id_instr(id_instr), .id_pc(id_pc), .id_ext_sel(id_ext_sel),
    .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_imm_ext(ex_imm_ext),
    .ex_ext_sel(ex_ext_sel), .ex_valid(ex_valid)
`ifdef STALL_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference pipeline state
  logic [31:0] m_id_instr, m_id_pc, m_ex_instr, m_ex_pc, m_ex_imm;
  logic [1:0]  m_ex_sel;
  logic        m_ex_valid;
  logic [31:0] m_cnt;

  function automatic logic [1:0] sel_of(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op inside {6'b001101, 6'b001100}) return 2'd0;
    if (op inside {6'b001001, 6'b001000, 6'b001010, 6'b100011, 6'b101011, 6'b000100}) return 2'd1;
    if (op == 6'b001111) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [31:0] ext_of(input logic [31:0] w);
    case (sel_of(w))
      2'd0: return 32'(w[15:0]);
      2'd1: return 32'($signed(w[15:0]));
      2'd2: return 32'(w[15:0]) * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  // A load-use hazard exists when the EX load writes a register ID reads.
  function automatic logic m_stall();
    logic [5:0] op;
    logic rd_rs, rd_rt;
    op    = m_id_instr[31:26];
    rd_rs = !(op inside {6'b001111, 6'b000010, 6'b000011});
    rd_rt = op inside {6'b000000, 6'b000100, 6'b101011};
    if (!ex_mem_read || ex_rt == 5'd0) return 1'b0;
    return (rd_rs && ex_rt == m_id_instr[25:21]) || (rd_rt && ex_rt == m_id_instr[20:16]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".id_instr"},   id_instr,           m_id_instr);
    chk({tag, ".id_pc"},      id_pc,              m_id_pc);
    chk({tag, ".id_sel"},     32'(id_ext_sel),    32'(sel_of(m_id_instr)));
    chk({tag, ".ex_instr"},   ex_instr,           m_ex_instr);
    chk({tag, ".ex_pc"},      ex_pc,              m_ex_pc);
    chk({tag, ".ex_imm"},     ex_imm_ext,         m_ex_imm);
    chk({tag, ".ex_sel"},     32'(ex_ext_sel),    32'(m_ex_sel));
    chk({tag, ".ex_valid"},   32'(ex_valid),      32'(m_ex_valid));
    chk({tag, ".stall"},      32'(stall),         32'(m_stall()));
`ifdef STALL_STATS_EN
    chk({tag, ".count"},      stall_count,        m_cnt);
`endif
  endtask

  task automatic model_reset();
    m_id_instr = 32'h0; m_id_pc = RST_PC;
    m_ex_instr = 32'h0; m_ex_pc = RST_PC;
    m_ex_imm = 32'h0; m_ex_sel = 2'd3; m_ex_valid = 1'b0; m_cnt = 32'h0;
  endtask

  // Inputs must already be driven; checks stall, clocks once, checks state.
  task automatic cycle(input string tag);
    logic s;
    #1;
    s = m_stall();
    chk({tag, ".pre_stall"}, 32'(stall), 32'(s));
    @(posedge clk);
    if (s) begin
      m_ex_instr = 32'h0; m_ex_imm = 32'h0; m_ex_sel = 2'd3; m_ex_valid = 1'b0;
      m_cnt = m_cnt + 32'd1;
    end else begin
      m_ex_instr = m_id_instr; m_ex_pc = m_id_pc;
      m_ex_imm = ext_of(m_id_instr); m_ex_sel = sel_of(m_id_instr); m_ex_valid = 1'b1;
    end
    if (flush) begin
      m_id_instr = 32'h0; m_id_pc = if_pc;
    end else if (!s) begin
      m_id_instr = if_instr; m_id_pc = if_pc;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                       input logic mr, input logic [4:0] rt);
    if_instr = ins; if_pc = pc; flush = fl; ex_mem_read = mr; ex_rt = rt;
  endtask

  logic [5:0] ops [14] = '{6'b000000, 6'b001101, 6'b001100, 6'b001001, 6'b001000,
                           6'b001010, 6'b100011, 6'b101011, 6'b000100, 6'b001111,
                           6'b000010, 6'b000011, 6'b000101, 6'b111111};

  initial begin
    drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    reset = 1'b1;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #3;
    reset = 1'b0;

    // Extender: zero, sign and upper
    drive(ORI, 32'h100, 1'b0, 1'b0, 5'd0);   cycle("ori_id");
    chk("ori_sel_const", 32'(id_ext_sel), 32'd0);
    drive(ADDIU, 32'h104, 1'b0, 1'b0, 5'd0); cycle("ori_ex");
    chk("ori_imm_const", ex_imm_ext, 32'h0000_8001);
    chk("ori_valid_const", 32'(ex_valid), 32'd1);
    drive(LUI3, 32'h108, 1'b0, 1'b0, 5'd0);  cycle("addiu_ex");
    chk("addiu_imm_const", ex_imm_ext, 32'hFFFF_8001);
    chk("addiu_sel_const", 32'(ex_ext_sel), 32'd1);
    drive(ADDU, 32'h10C, 1'b0, 1'b0, 5'd0);  cycle("lui_ex");
    chk("lui_imm_const", ex_imm_ext, 32'h1234_0000);
    chk("lui_sel_const", 32'(ex_ext_sel), 32'd2);

    // Load-use on rs: one-cycle stall with a bubble
    drive(32'hDEAD_BEEF, 32'h110, 1'b0, 1'b1, 5'd5);
    #1 chk("lu_stall_const", 32'(stall), 32'd1);
    cycle("lu_bubble");
    chk("lu_hold_const", id_instr, ADDU);
    chk("lu_bubble_const", ex_instr, 32'h0);
    drive(ADDU, 32'h114, 1'b0, 1'b0, 5'd0);  cycle("lu_resume");
    chk("lu_resume_const", ex_instr, ADDU);

    // No stall for ex_rt = 0, or for lui which reads no register
    drive(LUI5, 32'h118, 1'b0, 1'b1, 5'd0);  cycle("rt0_nostall");
    drive(BEQ, 32'h11C, 1'b0, 1'b1, 5'd5);   cycle("lui_nostall");
    chk("lui_valid_const", 32'(ex_valid), 32'd1);

    // Flush with beq in ID
    drive(ADDU, 32'h120, 1'b1, 1'b0, 5'd0);  cycle("flush_beq");
    chk("flush_beq_const", ex_instr, BEQ);
    drive(ADDU, 32'h124, 1'b0, 1'b0, 5'd0);  cycle("pre_fs");
    drive(ORI, 32'h128, 1'b1, 1'b1, 5'd7);   cycle("flush_stall");
    chk("fs_id_const", id_instr, 32'h0);
    chk("fs_ex_const", 32'(ex_valid), 32'd0);

    // Asynchronous reset while stalled
    drive(ADDU, 32'h12C, 1'b0, 1'b0, 5'd0);  cycle("pre_rst");
    drive(ORI, 32'h130, 1'b0, 1'b1, 5'd7);
    #1 chk("rst_stall_pre", 32'(stall), 32'd1);
    #1 reset = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    @(posedge clk); #2;
    check_all("rst_held");
    reset = 1'b0;

    // Three separate load-use stalls
    for (int i = 0; i < 3; i++) begin
      drive(ADDU, 32'h200 + 32'(i * 8), 1'b0, 1'b0, 5'd0); cycle("s3_load");
      drive(ORI, 32'h204 + 32'(i * 8), 1'b0, 1'b1, 5'd5);  cycle("s3_stall");
    end
`ifdef STALL_STATS_EN
    chk("stall_count_3", stall_count, 32'd3);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] w;
      w = {ops[$urandom_range(13)], 5'($urandom_range(7)), 5'($urandom_range(7)), 16'($urandom)};
      drive(w, $urandom, ($urandom_range(9) == 0), ($urandom_range(2) == 0), 5'($urandom_range(7)));
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
